instruction_fetch_unit: RTL



---
 rtl/instruction_fetch_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives instruction memory with fixed 1-cycle latency,
// buffers {instr, pc, fault} entries in a small FIFO and hands them to decode.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0100_0000,
  parameter logic [31:0] MEM_BASE     = 32'h0100_0000,
  parameter int unsigned MEM_BYTES    = 4096,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_read_enable,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc,
  output logic        fetch_fault
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            infl_valid_q, infl_valid_d;
  logic            infl_fault_q, infl_fault_d;
  logic [31:0]     infl_pc_q, infl_pc_d;

  logic [31:0]     buf_instr_q [FIFO_DEPTH];
  logic [31:0]     buf_pc_q    [FIFO_DEPTH];
  logic            buf_fault_q [FIFO_DEPTH];

  logic            pc_legal;
  logic            credit_ok;
  logic            issue_slot;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic [31:0]     push_instr;

  // In-flight reads hold a FIFO credit so a same-cycle pop never has to be counted.
  assign pc_legal   = (pc_q[1:0] == 2'b00) && (pc_q >= MEM_BASE) &&
                      ((pc_q - MEM_BASE) < 32'(MEM_BYTES));
  assign credit_ok  = (count_q + CW'(infl_valid_q)) < DEPTH_C;
  assign issue_slot = (state_q == RUN) && credit_ok;
  assign fifo_empty = (count_q == '0);
  assign push       = infl_valid_q && !redirect_valid;
  assign pop        = !fifo_empty && fetch_ready && !redirect_valid;
  assign push_instr = infl_fault_q ? NOP_INSTR : imem_instruction;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid)                state_d = RUN;
    else if (issue_slot && !pc_legal)  state_d = HALT;
  end

  // rst_n gate keeps the strobe low while reset is held even though state resets to RUN.
  always_comb begin
    imem_read_enable = issue_slot && pc_legal && rst_n;
    imem_address     = pc_q;
    fetch_valid      = !fifo_empty;
    fetch_instr      = '0;
    fetch_pc         = '0;
    fetch_fault      = 1'b0;
    if (!fifo_empty) begin
      fetch_instr = buf_instr_q[rd_ptr_q];
      fetch_pc    = buf_pc_q[rd_ptr_q];
      fetch_fault = buf_fault_q[rd_ptr_q];
    end
  end

  always_comb begin
    pc_d         = pc_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    infl_valid_d = 1'b0;
    infl_fault_d = infl_fault_q;
    infl_pc_d    = infl_pc_q;
    if (redirect_valid) begin
      pc_d         = redirect_pc;
      count_d      = '0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      infl_fault_d = 1'b0;
    end else begin
      if (issue_slot) begin
        infl_valid_d = 1'b1;
        infl_pc_d    = pc_q;
        infl_fault_d = !pc_legal;
        if (pc_legal) pc_d = pc_q + 32'd4;
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_VECTOR;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      infl_valid_q <= 1'b0;
      infl_fault_q <= 1'b0;
      infl_pc_q    <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        buf_instr_q[i] <= '0;
        buf_pc_q[i]    <= '0;
        buf_fault_q[i] <= 1'b0;
      end
    end else begin
      pc_q         <= pc_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      infl_valid_q <= infl_valid_d;
      infl_fault_q <= infl_fault_d;
      infl_pc_q    <= infl_pc_d;
      if (push) begin
        buf_instr_q[wr_ptr_q] <= push_instr;
        buf_pc_q[wr_ptr_q]    <= infl_pc_q;
        buf_fault_q[wr_ptr_q] <= infl_fault_q;
      end
    end
  end

endmodule
